pipe_nco_acc: RTL and testbench
===============================

Name: pipe_nco_acc

Overview:
- Parametrised, carry-pipelined phase accumulator for carrier and code NCOs in the GPS channel datapath.
- Successor to the single-bit carry-chain full-adder cell. The WIDTH-bit add is split into NSEG = WIDTH/SEG_W segments, and each segment's carry is registered between segments, so fmax is set by one SEG_W-bit carry chain.
- Input skew and output de-skew registers make the block behave as an ordinary accumulator delayed by NSEG cycles.

Parameters:
- WIDTH, 32, accumulator/phase width in bits.
- SEG_W, 8, segment width in bits. WIDTH must be an integer multiple of SEG_W. NSEG = WIDTH/SEG_W is derived locally; NSEG=1 is legal.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  add inc to the accumulator this cycle.
- inc  in  WIDTH  phase increment, unsigned, sampled when ena=1.
- load  in  1  overwrite the accumulator with load_val; priority over ena.
- load_val  in  WIDTH  load value.
- phase  out  WIDTH  accumulator value, de-skewed.
- phase_vld  out  1  phase reflects a sample where ena or load was 1.
- wrap  out  1  carry out of the MSB for that sample, one-cycle pulse aligned with phase.

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset clears every register, including skew/de-skew pipes, segment accumulators and carry registers. phase=0, phase_vld=0, wrap=0 while rst=1 and after release.
- Golden model, sampled at edge n:
  - load=1: A <= load_val, w=0.
  - else ena=1: {w,A} <= A + inc, i.e. a WIDTH+1-bit sum.
  - else: A holds, w=0.
  - At edge n+NSEG: phase = new A, wrap = w, phase_vld = ena|load of sample n. Latency is exactly NSEG cycles.
- Skew: segment k (k=0 is LSB) sees inc[k*SEG_W +: SEG_W], load_val slice, ena and load delayed k cycles.
- Segment k update (with delayed controls):
  - load: seg <= slice, carry_reg[k] <= 0.
  - ena: {carry_reg[k], seg} <= seg + inc slice + carry_reg[k-1]. carry_in for k=0 is 0.
  - neither: seg holds, carry_reg[k] <= 0.
- carry_reg[k-1] is always consumed, or is already zero, one cycle after it is produced, so no carry is lost across ena gaps.
- De-skew: segment k output is delayed NSEG-1-k further cycles. wrap = carry_reg[NSEG-1], with no further delay. phase_vld = (ena|load) delayed NSEG.
- Back-to-back ena, arbitrary gaps, and load followed immediately by ena must all match the golden model bit-exactly.
- Simultaneous load and ena: load wins and the increment is discarded.
- Modular arithmetic, no saturation; wrap reports each 2^WIDTH rollover.
- Reset mid-operation discards all in-flight samples. The first valid output after release corresponds to the first post-reset ena/load, from A=0.
- phase holds its last value when phase_vld=0, because the de-skew registers shift holding segments.

Optional Feature:
- PIPE_NCO_ACC_OUTREG_EN defined: phase, phase_vld and wrap pass through one extra register stage, reset to 0. Latency is NSEG+1; values are otherwise identical.
- Undefined: outputs come directly from the de-skew pipe, latency NSEG.

Test Plan:
- Reset value check, WIDTH=16, SEG_W=4: assert rst with stimulus active, then release -> phase=0, phase_vld=0, wrap=0 throughout reset, and no valid output for the first 4 cycles after release.
- Carry across segments: load 0x0FFE, then ena with inc=1 for 3 cycles -> phase 0x0FFE, 0x0FFF, 0x1000, 0x1001 on consecutive cycles, 4 cycles after each sample, with phase_vld=1.
- Full wrap: load 0xFFFF, then ena inc=0x0002 -> phase=0x0001 with wrap=1 for exactly one cycle; wrap=0 on the next sample.
- ena gaps across a carry: load 0x00FF, then alternate ena=1/0 with inc=1 -> phase 0x0100, then 0x0101 after the gap, phase_vld toggling, no lost or duplicated carry.
- Load with ena priority: inc=5, then load=1 and ena=1 in the same cycle with load_val=0x1234, then ena -> phase 0x1234, then 0x1239.
- Random ena, load and inc over 100k cycles against the golden model, for (32,8), (16,4) and NSEG=1 (8,8), with the macro both defined and undefined -> bit-exact match on phase, wrap and phase_vld.

Source files
------------

// File: rtl/pipe_nco_acc.sv
// Carry-pipelined NCO phase accumulator: SEG_W-bit segments with registered inter-segment carries.
// Optional macro PIPE_NCO_ACC_OUTREG_EN adds one output register stage (latency NSEG+1).
module pipe_nco_acc #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] phase,
    output logic             phase_vld,
    output logic             wrap
);
    localparam int NSEG = WIDTH / SEG_W;

    logic [NSEG-1:0]  carry_vec;
    logic [WIDTH-1:0] phase_d;
    logic [NSEG-1:0]  vld_p;
    logic             vld_d;
    logic             wrap_d;

    genvar k;
    generate
        for (k = 0; k < NSEG; k++) begin : g_seg
            logic [SEG_W-1:0] inc_k;
            logic [SEG_W-1:0] val_k;
            logic             ena_k;
            logic             load_k;
            logic             cin;
            logic [SEG_W-1:0] seg_q;
            logic             carry_r;
            logic [SEG_W:0]   sum_k;

            // Segment k runs k cycles behind the LSB segment so that it meets the carry it needs.
            if (k == 0) begin : g_noskew
                assign inc_k  = inc[SEG_W-1:0];
                assign val_k  = load_val[SEG_W-1:0];
                assign ena_k  = ena;
                assign load_k = load;
                assign cin    = 1'b0;
            end else begin : g_skew
                logic [SEG_W-1:0] inc_p [k];
                logic [SEG_W-1:0] val_p [k];
                logic [k-1:0]     ena_p;
                logic [k-1:0]     load_p;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < k; i++) begin
                            inc_p[i] <= '0;
                            val_p[i] <= '0;
                        end
                        ena_p  <= '0;
                        load_p <= '0;
                    end else begin
                        inc_p[0]  <= inc[k*SEG_W +: SEG_W];
                        val_p[0]  <= load_val[k*SEG_W +: SEG_W];
                        ena_p[0]  <= ena;
                        load_p[0] <= load;
                        for (int i = 1; i < k; i++) begin
                            inc_p[i]  <= inc_p[i-1];
                            val_p[i]  <= val_p[i-1];
                            ena_p[i]  <= ena_p[i-1];
                            load_p[i] <= load_p[i-1];
                        end
                    end
                end

                assign inc_k  = inc_p[k-1];
                assign val_k  = val_p[k-1];
                assign ena_k  = ena_p[k-1];
                assign load_k = load_p[k-1];
                assign cin    = carry_vec[k-1];
            end

            assign sum_k = {1'b0, seg_q} + {1'b0, inc_k} + {{SEG_W{1'b0}}, cin};

            // A carry is cleared on idle/load cycles so a stale carry never leaks into a later add.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    seg_q   <= '0;
                    carry_r <= 1'b0;
                end else if (load_k) begin
                    seg_q   <= val_k;
                    carry_r <= 1'b0;
                end else if (ena_k) begin
                    {carry_r, seg_q} <= sum_k;
                end else begin
                    carry_r <= 1'b0;
                end
            end

            assign carry_vec[k] = carry_r;

            if (k == NSEG - 1) begin : g_nodeskew
                assign phase_d[k*SEG_W +: SEG_W] = seg_q;
            end else begin : g_deskew
                logic [SEG_W-1:0] out_p [NSEG-1-k];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < NSEG - 1 - k; i++) begin
                            out_p[i] <= '0;
                        end
                    end else begin
                        out_p[0] <= seg_q;
                        for (int i = 1; i < NSEG - 1 - k; i++) begin
                            out_p[i] <= out_p[i-1];
                        end
                    end
                end

                assign phase_d[k*SEG_W +: SEG_W] = out_p[NSEG-2-k];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= ena | load;
            for (int i = 1; i < NSEG; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign vld_d  = vld_p[NSEG-1];
    assign wrap_d = carry_vec[NSEG-1];

`ifdef PIPE_NCO_ACC_OUTREG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= '0;
            phase_vld <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            phase     <= phase_d;
            phase_vld <= vld_d;
            wrap      <= wrap_d;
        end
    end
`else
    assign phase     = phase_d;
    assign phase_vld = vld_d;
    assign wrap      = wrap_d;
`endif

endmodule

// File: tb/tb_pipe_nco_acc.sv
// Directed-vector and golden-model bench for pipe_nco_acc at WIDTH=16, SEG_W=4.
// Honours PIPE_NCO_ACC_OUTREG_EN by adding one cycle to the expected latency.
module tb_pipe_nco_acc;
    localparam int WIDTH = 16;
    localparam int SEG_W = 4;
    localparam int NSEG  = WIDTH / SEG_W;
`ifdef PIPE_NCO_ACC_OUTREG_EN
    localparam int LAT = NSEG + 1;
`else
    localparam int LAT = NSEG;
`endif
    localparam int NVEC = 21;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] inc = '0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] phase;
    logic             phase_vld;
    logic             wrap;

    pipe_nco_acc #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .inc      (inc),
        .load     (load),
        .load_val (load_val),
        .phase    (phase),
        .phase_vld(phase_vld),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             load;
        logic             ena;
        logic [WIDTH-1:0] load_val;
        logic [WIDTH-1:0] inc;
        logic [WIDTH-1:0] exp_phase;
        logic             exp_vld;
        logic             exp_wrap;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] phase;
        logic             vld;
        logic             wrap;
    } exp_t;

    vec_t             vecs [NVEC];
    exp_t             exp_q [$];
    logic [WIDTH-1:0] model_a;
    int               total = 0;
    int               bad = 0;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] ep,
                               input logic ev, input logic ew);
        total++;
        if (phase !== ep || phase_vld !== ev || wrap !== ew) begin
            bad++;
            $display("[TB] FAIL %s: got phase=%h vld=%b wrap=%b, expected phase=%h vld=%b wrap=%b",
                     name, phase, phase_vld, wrap, ep, ev, ew);
        end
    endtask

    // Drive one sample and advance to just after the edge that captures it.
    task automatic applyStimulus(input logic l, input logic e,
                                 input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] i);
        load     = l;
        ena      = e;
        load_val = lv;
        inc      = i;
        @(posedge clk);
        #1;
    endtask

    task automatic pushAndCheck(input string name, input exp_t x);
        exp_t y;
        exp_q.push_back(x);
        if (exp_q.size() == LAT) begin
            y = exp_q.pop_front();
            checkOutput(name, y.phase, y.vld, y.wrap);
        end
    endtask

    // Golden accumulator: one WIDTH+1-bit add per enabled sample, load has priority.
    task automatic stepModel(input string name, input logic l, input logic e,
                             input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] i);
        exp_t       x;
        logic [WIDTH:0] s;
        if (l) begin
            model_a = lv;
            x = '{phase: lv, vld: 1'b1, wrap: 1'b0};
        end else if (e) begin
            s = {1'b0, model_a} + {1'b0, i};
            model_a = s[WIDTH-1:0];
            x = '{phase: model_a, vld: 1'b1, wrap: s[WIDTH]};
        end else begin
            x = '{phase: model_a, vld: 1'b0, wrap: 1'b0};
        end
        applyStimulus(l, e, lv, i);
        pushAndCheck(name, x);
    endtask

    task automatic restartModel();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
        model_a = '0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'h0FFE, 16'h0000, 16'h0FFE, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0FFF, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h1000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h1001, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0001, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0003, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h00FF, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0100, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0100, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0101, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0101, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 16'h0000, 16'h0005, 16'h0106, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 16'h1234, 16'h0005, 16'h1234, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 16'h0000, 16'h0005, 16'h1239, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h1239, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 16'h0000, 16'hEDC7, 16'h0000, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 16'h0000, 16'h0F0F, 16'h0F0F, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 1'b0, 1'b0};

        // Reset held with live stimulus: outputs must stay cleared.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(c[0], 1'b1, 16'hABCD, 16'h1111);
            checkOutput($sformatf("reset_hold%0d", c), '0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        restartModel();
        for (int c = 0; c < 6; c++) begin
            stepModel($sformatf("post_reset%0d", c), 1'b0, 1'b1, 16'h0000, 16'h0003);
        end

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].load, vecs[i].ena, vecs[i].load_val, vecs[i].inc);
            pushAndCheck($sformatf("vec%0d", i),
                         '{phase: vecs[i].exp_phase, vld: vecs[i].exp_vld, wrap: vecs[i].exp_wrap});
        end
        model_a = vecs[NVEC-1].exp_phase;

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b1;
                #1;
                checkOutput("async_reset", '0, 1'b0, 1'b0);
                @(posedge clk);
                #1;
                checkOutput("async_reset_held", '0, 1'b0, 1'b0);
                rst = 1'b0;
                restartModel();
            end
            stepModel($sformatf("rand%0d", c),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
                      WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(0, 65535)));
        end

        for (int c = 0; c < LAT; c++) begin
            stepModel($sformatf("drain%0d", c), 1'b0, 1'b0, '0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
